// File: rtl/cdb_arb.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arb
// Brief    : Common data bus arbiter. Buffers completions from NUM_SRC
//            functional-unit ports in per-source FIFOs and broadcasts up to
//            NUM_CDB of them per cycle, round-robin, with flush support.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arb #(
    parameter int                 NUM_SRC  = 6,
    parameter int                 NUM_CDB  = 4,
    parameter int                 PR_W     = 7,
    parameter int                 AR_W     = 5,
    parameter int                 DEPTH    = 2,
    parameter logic [NUM_SRC-1:0] EXC_MASK = 6'b110011
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_ready,
    input  logic [NUM_SRC*PR_W-1:0]             src_pr,
    input  logic [NUM_SRC*AR_W-1:0]             src_ar,
    input  logic [NUM_SRC-1:0]                  src_exc,
    output logic [NUM_CDB-1:0]                  cdb_valid,
    output logic [NUM_CDB*PR_W-1:0]             cdb_pr,
    output logic [NUM_CDB*AR_W-1:0]             cdb_ar,
    output logic [NUM_CDB-1:0]                  cdb_exc,
    output logic [NUM_CDB*$clog2(NUM_SRC)-1:0]  cdb_src
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Entry layout: {pr, ar, exc}
    localparam int ENT_W = PR_W + AR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    // Per-source FIFO state
    logic [ENT_W-1:0] mem_q   [NUM_SRC][DEPTH];
    logic [ENT_W-1:0] mem_d   [NUM_SRC][DEPTH];
    logic [PTR_W-1:0] head_q  [NUM_SRC];
    logic [PTR_W-1:0] head_d  [NUM_SRC];
    logic [PTR_W-1:0] tail_q  [NUM_SRC];
    logic [PTR_W-1:0] tail_d  [NUM_SRC];
    logic [CNT_W-1:0] count_q [NUM_SRC];
    logic [CNT_W-1:0] count_d [NUM_SRC];

    // Round-robin pointer and broadcast registers
    logic [SRC_W-1:0]          rr_q, rr_d;
    logic [NUM_CDB-1:0]        cdb_valid_q, cdb_valid_d;
    logic [NUM_CDB*PR_W-1:0]   cdb_pr_q, cdb_pr_d;
    logic [NUM_CDB*AR_W-1:0]   cdb_ar_q, cdb_ar_d;
    logic [NUM_CDB-1:0]        cdb_exc_q, cdb_exc_d;
    logic [NUM_CDB*SRC_W-1:0]  cdb_src_q, cdb_src_d;

    // Per-source candidate view
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] has_head;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] grant;
    logic [ENT_W-1:0]   in_ent   [NUM_SRC];
    logic [ENT_W-1:0]   cand_ent [NUM_SRC];

    // Arbitration scan scratch
    int arb_idx;
    int arb_slot;
    int arb_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Single-entry FIFOs keep their pointers at zero
        if (DEPTH == 1) return '0;
        return p + PTR_W'(1);
    endfunction

    // Ready depends only on occupancy so sources never see a same-cycle
    // dequeue through a combinational path.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_ready[gi] = (count_q[gi] < C_DEPTH);
        assign accept[gi]    = src_valid[gi] & src_ready[gi];
        assign has_head[gi]  = (count_q[gi] != '0);
        assign cand[gi]      = has_head[gi] | accept[gi];
        assign in_ent[gi]    = {src_pr[gi*PR_W +: PR_W],
                                src_ar[gi*AR_W +: AR_W],
                                src_exc[gi] & EXC_MASK[gi]};
        // An empty FIFO lets an incoming completion bypass straight to the bus
        assign cand_ent[gi]  = has_head[gi] ? mem_q[gi][head_q[gi]] : in_ent[gi];
    end

    // Round-robin scan from rr: the k-th candidate found drives slot k.
    always_comb begin
        grant       = '0;
        cdb_valid_d = '0;
        cdb_pr_d    = cdb_pr_q;
        cdb_ar_d    = cdb_ar_q;
        cdb_exc_d   = cdb_exc_q;
        cdb_src_d   = cdb_src_q;
        arb_idx     = 0;
        arb_slot    = 0;
        arb_last    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            arb_idx = int'(rr_q) + k;
            if (arb_idx >= NUM_SRC) arb_idx = arb_idx - NUM_SRC;
            if (cand[arb_idx] && (arb_slot < NUM_CDB)) begin
                grant[arb_idx]                     = 1'b1;
                cdb_valid_d[arb_slot]              = 1'b1;
                cdb_pr_d[arb_slot*PR_W +: PR_W]    = cand_ent[arb_idx][ENT_W-1 -: PR_W];
                cdb_ar_d[arb_slot*AR_W +: AR_W]    = cand_ent[arb_idx][AR_W:1];
                cdb_exc_d[arb_slot]                = cand_ent[arb_idx][0];
                cdb_src_d[arb_slot*SRC_W +: SRC_W] = SRC_W'(arb_idx);
                arb_last                           = arb_idx;
                arb_slot                           = arb_slot + 1;
            end
        end
        if (arb_slot == 0)
            rr_d = rr_q;
        else if (arb_last == NUM_SRC - 1)
            rr_d = '0;
        else
            rr_d = SRC_W'(arb_last + 1);
        // Squash kills this cycle's broadcasts but keeps fairness state
        if (flush) begin
            cdb_valid_d = '0;
            rr_d        = rr_q;
        end
    end

    // FIFO next state: granted heads pop, non-bypassed accepts push.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (flush) begin
                head_d[i]  = '0;
                tail_d[i]  = '0;
                count_d[i] = '0;
            end else begin
                if (accept[i] && !(grant[i] && !has_head[i])) begin
                    mem_d[i][tail_q[i]] = in_ent[i];
                    tail_d[i]           = ptr_inc(tail_q[i]);
                    if (!(grant[i] && has_head[i]))
                        count_d[i] = count_q[i] + CNT_W'(1);
                end else if (grant[i] && has_head[i]) begin
                    count_d[i] = count_q[i] - CNT_W'(1);
                end
                if (grant[i] && has_head[i])
                    head_d[i] = ptr_inc(head_q[i]);
            end
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Round-robin pointer and registered broadcast slots
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q        <= '0;
            cdb_valid_q <= '0;
            cdb_pr_q    <= '0;
            cdb_ar_q    <= '0;
            cdb_exc_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_pr_q    <= cdb_pr_d;
            cdb_ar_q    <= cdb_ar_d;
            cdb_exc_q   <= cdb_exc_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_pr    = cdb_pr_q;
    assign cdb_ar    = cdb_ar_q;
    assign cdb_exc   = cdb_exc_q;
    assign cdb_src   = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arb
// Brief    : Directed self-checking bench for cdb_arb (default build plus a
//            single-slot build for backpressure ordering).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;

    // Default build: 6 sources, 4 slots
    logic [5:0]  src_valid;
    logic [5:0]  src_ready;
    logic [41:0] src_pr;
    logic [29:0] src_ar;
    logic [5:0]  src_exc;
    logic [3:0]  cdb_valid;
    logic [27:0] cdb_pr;
    logic [19:0] cdb_ar;
    logic [3:0]  cdb_exc;
    logic [11:0] cdb_src;

    // Single-slot build
    logic [5:0]  b_valid;
    logic [5:0]  b_ready;
    logic [41:0] b_pr;
    logic [29:0] b_ar;
    logic [5:0]  b_exc;
    logic [0:0]  b_cdb_valid;
    logic [6:0]  b_cdb_pr;
    logic [4:0]  b_cdb_ar;
    logic [0:0]  b_cdb_exc;
    logic [2:0]  b_cdb_src;

    int errors = 0;
    int checks = 0;

    cdb_arb dut (
        .clock(clock), .reset(reset), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_pr(src_pr), .src_ar(src_ar), .src_exc(src_exc),
        .cdb_valid(cdb_valid), .cdb_pr(cdb_pr), .cdb_ar(cdb_ar),
        .cdb_exc(cdb_exc), .cdb_src(cdb_src)
    );

    cdb_arb #(.NUM_CDB(1)) dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .src_valid(b_valid), .src_ready(b_ready),
        .src_pr(b_pr), .src_ar(b_ar), .src_exc(b_exc),
        .cdb_valid(b_cdb_valid), .cdb_pr(b_cdb_pr), .cdb_ar(b_cdb_ar),
        .cdb_exc(b_cdb_exc), .cdb_src(b_cdb_src)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        src_valid = '0; src_pr = '0; src_ar = '0; src_exc = '0;
        b_valid   = '0; b_pr   = '0; b_ar   = '0; b_exc   = '0;
    endtask

    task automatic set_src(input int i, input int pr, input int ar, input bit exc);
        src_valid[i]       = 1'b1;
        src_pr[i*7 +: 7]   = 7'(pr);
        src_ar[i*5 +: 5]   = 5'(ar);
        src_exc[i]         = exc;
    endtask

    task automatic do_reset();
        clear_inputs();
        flush = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cdb_valid !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b want 0000", cdb_valid); end
        checks++; if (src_ready !== 6'b111111) begin errors++; $display("FAIL reset_ready: got %b want 111111", src_ready); end
        checks++; if (cdb_pr !== 28'd0 || cdb_ar !== 20'd0) begin errors++; $display("FAIL reset_tags: pr %h ar %h want 0", cdb_pr, cdb_ar); end
        checks++; if (cdb_exc !== 4'd0 || cdb_src !== 12'd0) begin errors++; $display("FAIL reset_exc_src: exc %b src %h want 0", cdb_exc, cdb_src); end
        checks++; if (b_cdb_valid !== 1'b0 || b_cdb_pr !== 7'd0 || b_cdb_ar !== 5'd0 || b_cdb_exc !== 1'b0 || b_cdb_src !== 3'd0) begin
            errors++; $display("FAIL reset_b: got v%b pr%0d ar%0d exc%b src%0d want zeros", b_cdb_valid, b_cdb_pr, b_cdb_ar, b_cdb_exc, b_cdb_src); end
    endtask

    task automatic test_single();
        set_src(2, 45, 3, 1'b0);
        step();
        clear_inputs();
        checks++; if (cdb_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b want 0001", cdb_valid); end
        checks++; if (cdb_pr[6:0] !== 7'd45) begin errors++; $display("FAIL single_pr: got %0d want 45", cdb_pr[6:0]); end
        checks++; if (cdb_ar[4:0] !== 5'd3) begin errors++; $display("FAIL single_ar: got %0d want 3", cdb_ar[4:0]); end
        checks++; if (cdb_src[2:0] !== 3'd2) begin errors++; $display("FAIL single_src: got %0d want 2", cdb_src[2:0]); end
        step();
        checks++; if (cdb_valid !== 4'b0000) begin errors++; $display("FAIL single_nodup: got %b want 0000", cdb_valid); end
    endtask

    task automatic test_oversub();
        do_reset();
        for (int i = 0; i < 6; i++) set_src(i, 10 + i, i, 1'b0);
        step();
        clear_inputs();
        checks++; if (cdb_valid !== 4'b1111) begin errors++; $display("FAIL over_valid0: got %b want 1111", cdb_valid); end
        checks++; if (cdb_src !== {3'd3, 3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL over_src0: got %h want %h", cdb_src, {3'd3, 3'd2, 3'd1, 3'd0}); end
        checks++; if (cdb_pr !== {7'd13, 7'd12, 7'd11, 7'd10}) begin errors++; $display("FAIL over_pr0: got %h want %h", cdb_pr, {7'd13, 7'd12, 7'd11, 7'd10}); end
        step();
        checks++; if (cdb_valid !== 4'b0011) begin errors++; $display("FAIL over_valid1: got %b want 0011", cdb_valid); end
        checks++; if (cdb_src[5:0] !== {3'd5, 3'd4}) begin errors++; $display("FAIL over_src1: got %h want %h", cdb_src[5:0], {3'd5, 3'd4}); end
        checks++; if (cdb_pr[13:0] !== {7'd15, 7'd14}) begin errors++; $display("FAIL over_pr1: got %h want %h", cdb_pr[13:0], {7'd15, 7'd14}); end
        // rr is now 0: sources 0 and 5 must come out in that order
        set_src(0, 20, 0, 1'b0);
        set_src(5, 25, 5, 1'b0);
        step();
        clear_inputs();
        checks++; if (cdb_valid !== 4'b0011 || cdb_src[5:0] !== {3'd5, 3'd0}) begin
            errors++; $display("FAIL over_rr: valid %b src %h want 0011 %h", cdb_valid, cdb_src[5:0], {3'd5, 3'd0}); end
        step();
    endtask

    task automatic test_exc();
        // rr = 0 here
        set_src(2, 30, 2, 1'b1);
        set_src(4, 34, 4, 1'b1);
        step();
        clear_inputs();
        checks++; if (cdb_valid !== 4'b0011 || cdb_src[5:0] !== {3'd4, 3'd2}) begin
            errors++; $display("FAIL exc_order: valid %b src %h want 0011 %h", cdb_valid, cdb_src[5:0], {3'd4, 3'd2}); end
        checks++; if (cdb_exc[1:0] !== 2'b10) begin errors++; $display("FAIL exc_mask: got %b want 10", cdb_exc[1:0]); end
        step();
    endtask

    task automatic test_flush();
        // rr = 5: grants 5,0,1,2; sources 3,4 are buffered; rr becomes 3
        for (int i = 0; i < 6; i++) set_src(i, 40 + i, i, 1'b0);
        step();
        clear_inputs();
        checks++; if (cdb_valid !== 4'b1111 || cdb_src !== {3'd2, 3'd1, 3'd0, 3'd5}) begin
            errors++; $display("FAIL flush_pre: valid %b src %h want 1111 %h", cdb_valid, cdb_src, {3'd2, 3'd1, 3'd0, 3'd5}); end
        flush = 1'b1;
        set_src(0, 50, 0, 1'b0);
        #1;
        checks++; if (src_ready !== 6'b111111) begin errors++; $display("FAIL flush_ready: got %b want 111111", src_ready); end
        step();
        flush = 1'b0;
        clear_inputs();
        checks++; if (cdb_valid !== 4'b0000) begin errors++; $display("FAIL flush_valid: got %b want 0000", cdb_valid); end
        step();
        checks++; if (cdb_valid !== 4'b0000) begin errors++; $display("FAIL flush_stale: got %b want 0000", cdb_valid); end
        // rr kept at 3; FIFO 3 must not replay its squashed head (43)
        set_src(2, 52, 2, 1'b0);
        set_src(3, 53, 3, 1'b0);
        step();
        clear_inputs();
        checks++; if (cdb_valid !== 4'b0011 || cdb_src[5:0] !== {3'd2, 3'd3}) begin
            errors++; $display("FAIL flush_rr: valid %b src %h want 0011 %h", cdb_valid, cdb_src[5:0], {3'd2, 3'd3}); end
        checks++; if (cdb_pr[13:0] !== {7'd52, 7'd53}) begin errors++; $display("FAIL flush_pr: got %h want %h", cdb_pr[13:0], {7'd52, 7'd53}); end
        step();
    endtask

    task automatic test_back_to_back();
        int n0, n1, e0, e1;
        logic acc0, acc1;
        logic [2:0] prev;
        int exp_pr;
        n0 = 0; n1 = 0; e0 = 0; e1 = 0; prev = 3'd7;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            if (c < 10) begin
                b_valid = 6'b000011;
                b_pr[6:0]  = 7'(16 + n0);
                b_pr[13:7] = 7'(32 + n1);
            end else begin
                b_valid = '0;
            end
            #1;
            acc0 = b_valid[0] & b_ready[0];
            acc1 = b_valid[1] & b_ready[1];
            if (c == 3) begin
                checks++; if (b_ready !== 6'b111101) begin errors++; $display("FAIL b2b_ready1: got %b want 111101", b_ready); end
            end
            if (c == 4) begin
                checks++; if (b_ready !== 6'b111110) begin errors++; $display("FAIL b2b_ready0: got %b want 111110", b_ready); end
            end
            @(posedge clock);
            #1;
            if (acc0) n0++;
            if (acc1) n1++;
            if (c < 10) begin
                checks++; if (b_cdb_valid !== 1'b1 || b_cdb_src === prev) begin
                    errors++; $display("FAIL b2b_alternate: cycle %0d valid %b src %0d prev %0d", c, b_cdb_valid, b_cdb_src, prev); end
            end
            if (b_cdb_valid === 1'b1) begin
                if (b_cdb_src === 3'd0) begin
                    exp_pr = 16 + e0; e0++;
                end else if (b_cdb_src === 3'd1) begin
                    exp_pr = 32 + e1; e1++;
                end else begin
                    exp_pr = -1;
                end
                checks++; if (exp_pr < 0 || b_cdb_pr !== 7'(exp_pr)) begin
                    errors++; $display("FAIL b2b_order: cycle %0d src %0d pr %0d want %0d", c, b_cdb_src, b_cdb_pr, exp_pr); end
                prev = b_cdb_src;
            end
        end
        checks++; if (e0 != n0 || e1 != n1) begin
            errors++; $display("FAIL b2b_count: broadcast %0d/%0d accepted %0d/%0d", e0, e1, n0, n1); end
        checks++; if (b_cdb_valid !== 1'b0 || b_ready !== 6'b111111) begin
            errors++; $display("FAIL b2b_drain: valid %b ready %b want 0 111111", b_cdb_valid, b_ready); end
    endtask

    initial begin
        clear_inputs();
        flush = 1'b0;
        reset = 1'b1;
        test_reset();
        test_single();
        test_oversub();
        test_exc();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arb.md
Name: cdb_arb

Overview:
- Parametrised common data bus with arbitration. It gathers completions from NUM_SRC functional-unit result ports, buffers them per source, and broadcasts up to NUM_CDB per cycle to the RS, ROB and map table.
- Sits between the execute stage and the RS/ROB/MT wakeup logic. It replaces the fixed one-bus-per-unit broadcast with round-robin arbitration, backpressure and flush.

Parameters:
- NUM_SRC, 6, number of completing FU ports.
- NUM_CDB, 4, broadcast slots per cycle (1..NUM_SRC).
- PR_W, 7, physical register tag width.
- AR_W, 5, architectural register tag width.
- DEPTH, 2, per-source FIFO entries (power of 2, >=1).
- EXC_MASK, 6'b110011, bit i=1 means source i may raise an exception; bit i=0 forces exception to 0.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash (mispredict/exception recovery).
- src_valid  in  NUM_SRC  completion valid per source.
- src_ready  out  NUM_SRC  source may present a completion; combinational from FIFO state only.
- src_pr  in  NUM_SRC*PR_W  packed PR tags; source i at [i*PR_W +: PR_W].
- src_ar  in  NUM_SRC*AR_W  packed AR tags.
- src_exc  in  NUM_SRC  exception flag per source.
- cdb_valid  out  NUM_CDB  registered broadcast valid per slot.
- cdb_pr  out  NUM_CDB*PR_W  registered PR tag per slot.
- cdb_ar  out  NUM_CDB*AR_W  registered AR tag per slot.
- cdb_exc  out  NUM_CDB  registered exception per slot.
- cdb_src  out  NUM_CDB*clog2(NUM_SRC)  registered originating source index per slot.

Behaviour:
- Reset:
  - All outputs zero.
  - All FIFOs empty.
  - Round-robin pointer rr=0.
  - src_ready = all ones the cycle after reset deasserts.
- Accept: source i is accepted when src_valid[i] & src_ready[i]. src_ready[i] = (count_i < DEPTH) and does not depend on same-cycle dequeue.
- Candidate per source:
  - If the FIFO is non-empty, the candidate is the FIFO head.
  - If the FIFO is empty and an accept occurs, the candidate is the incoming entry (bypass).
  - Otherwise there is no candidate.
- Arbitration (combinational, in cycle t):
  - Scan sources rr, rr+1, ... mod NUM_SRC.
  - Grant the first min(#candidates, NUM_CDB) candidates.
  - The k-th grant in scan order drives slot k.
  - Unused slots get valid=0, and their tags hold the previous value (don't care).
- Output register: grants are registered at the edge ending cycle t and visible in cycle t+1. Uncontended latency is therefore 1 cycle, matching the previous CDB.
- FIFO update per source at the edge:
  - A granted head dequeues.
  - A bypass grant writes nothing.
  - A non-granted accept enqueues at the tail.
  - Head granted plus new accept: dequeue and enqueue in the same edge; count unchanged.
  - Order within a source is strictly FIFO.
- rr update: rr <= (index of last granted source + 1) mod NUM_SRC. It is unchanged if there are no grants.
- Exception: the stored exception bit is src_exc[i] & EXC_MASK[i].
- Flush (has priority over normal operation, not over reset):
  - At the edge it empties all FIFOs and sets cdb_valid <= 0.
  - Same-cycle accepts are dropped.
  - rr is unchanged.
  - src_ready stays as computed combinationally that cycle.
- Reset mid-operation clears everything, including in-flight FIFO contents, at the next edge.
- Wrap-around: the FIFO pointers are clog2(DEPTH)-bit and wrap; count is clog2(DEPTH)+1 bits.
- No entry may be lost or duplicated. Total entries broadcast = total accepted minus entries dropped by flush.

Test Plan:
- Reset then idle: cdb_valid=0, src_ready=6'b111111, all tags 0.
- Single completion: src 2 valid, pr=7'd45, ar=5'd3 in cycle t -> cycle t+1 cdb_valid=4'b0001, cdb_pr slot0=45, cdb_ar slot0=3, cdb_src slot0=2; FIFO 2 stays empty.
- Oversubscription: all 6 sources valid in one cycle with rr=0 -> slots 0..3 = src 0,1,2,3; src 4,5 enqueue, rr=4. Next cycle with no new input -> slots 0,1 = src 4,5 and rr=0.
- Backpressure: NUM_CDB=1, src 0 and src 1 valid every cycle -> src 1 fills DEPTH=2 and src_ready[1]=0. Grants alternate between sources, and each source's PR sequence is broadcast in order with no loss.
- Exception mask: src 2 valid with exc=1 -> broadcast exc=0. src 4 valid with exc=1 -> broadcast exc=1.
- Flush: FIFOs holding 3 entries plus flush=1 with src 0 valid -> next cycle cdb_valid=0 and all FIFOs empty; the following cycle produces no stale broadcasts.
